// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared channel width, luma weights and pixel type for the
//            gray stream arbiter.
// Revision : 1.0
// ============================================================================
package gray_pkg;

    localparam int CW      = 10;
    localparam int W_RED   = 306;
    localparam int W_GREEN = 601;
    localparam int W_BLUE  = 117;
    localparam int W_SHIFT = 10;

    typedef struct packed {
        logic [CW-1:0] red;
        logic [CW-1:0] green;
        logic [CW-1:0] blue;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/gray_core.sv
`default_nettype none
// ============================================================================
// Module   : gray_core
// Purpose  : Combinational weighted-sum luma, truncated (no rounding).
// Revision : 1.0
// ============================================================================
module gray_core
    import gray_pkg::*;
#(
    parameter int CW = gray_pkg::CW
) (
    input  logic [CW-1:0] iRed,
    input  logic [CW-1:0] iGreen,
    input  logic [CW-1:0] iBlue,
    output logic [CW-1:0] oGray
);

    // Weights sum to 2^W_SHIFT, so the sum never exceeds CW+W_SHIFT bits.
    localparam int SW = CW + W_SHIFT;

    logic [SW-1:0] sum;

    assign sum   = SW'(iRed)   * SW'(W_RED)
                 + SW'(iGreen) * SW'(W_GREEN)
                 + SW'(iBlue)  * SW'(W_BLUE);
    assign oGray = CW'(sum >> W_SHIFT);

endmodule
`default_nettype wire

// File: rtl/gray_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_arbiter
// Purpose  : Two-requester round-robin arbiter with optional per-requester
//            grayscale conversion and a single registered output slot.
// Revision : 1.0
// ============================================================================
module gray_stream_arbiter
    import gray_pkg::*;
#(
    parameter int CW = gray_pkg::CW,
    parameter int NW = 16
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iValid0,
    input  logic          iValid1,
    output logic          oReady0,
    output logic          oReady1,
    input  logic [CW-1:0] iRed0,
    input  logic [CW-1:0] iGreen0,
    input  logic [CW-1:0] iBlue0,
    input  logic [CW-1:0] iRed1,
    input  logic [CW-1:0] iGreen1,
    input  logic [CW-1:0] iBlue1,
    input  logic [1:0]    iMode,
    output logic          oValid,
    input  logic          iOutReady,
    output logic [CW-1:0] oRed,
    output logic [CW-1:0] oGreen,
    output logic [CW-1:0] oBlue,
    output logic          oSrc,
    output logic [NW-1:0] oCount0,
    output logic [NW-1:0] oCount1
);

    logic          valid_q, valid_d;
    logic [CW-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic          src_q, src_d;
    logic          last_q, last_d;
    logic [NW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic          grant0, grant1, slot_free, acc0, acc1, accept, sel;
    logic [CW-1:0] sel_r, sel_g, sel_b, gray;

    always_comb begin
        grant0 = iValid0;
        grant1 = iValid1;
        // On a tie the requester not served last wins.
        if (iValid0 && iValid1) begin
            grant0 = last_q;
            grant1 = !last_q;
        end
    end

    assign slot_free = !valid_q || iOutReady;
    assign acc0      = grant0 && slot_free && !iRST;
    assign acc1      = grant1 && slot_free && !iRST;
    assign accept    = acc0 || acc1;
    assign sel       = grant1;
    assign oReady0   = acc0;
    assign oReady1   = acc1;

    assign sel_r = sel ? iRed1   : iRed0;
    assign sel_g = sel ? iGreen1 : iGreen0;
    assign sel_b = sel ? iBlue1  : iBlue0;

    gray_core #(.CW(CW)) u_gray (
        .iRed   (sel_r),
        .iGreen (sel_g),
        .iBlue  (sel_b),
        .oGray  (gray)
    );

    always_comb begin
        valid_d = valid_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (accept) begin
            valid_d = 1'b1;
            src_d   = sel;
            last_d  = sel;
            red_d   = iMode[sel] ? gray : sel_r;
            green_d = iMode[sel] ? gray : sel_g;
            blue_d  = iMode[sel] ? gray : sel_b;
        end else if (iOutReady) begin
            valid_d = 1'b0;
        end
        if (acc0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (acc1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            valid_q <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            valid_q <= valid_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign oValid  = valid_q;
    assign oRed    = red_q;
    assign oGreen  = green_q;
    assign oBlue   = blue_q;
    assign oSrc    = src_q;
    assign oCount0 = cnt0_q;
    assign oCount1 = cnt1_q;

endmodule
`default_nettype wire
